// File: rtl/gate_interlock_pkg.sv
// Shared definitions for the gate interlock: per-leg state encoding,
// fault codes and leg indices.
package gate_interlock_pkg;

    typedef enum logic [2:0] {
        LEG_OFF     = 3'd0,
        LEG_HI_ON   = 3'd1,
        LEG_LO_ON   = 3'd2,
        LEG_DEAD_HL = 3'd3,
        LEG_DEAD_LH = 3'd4
    } leg_state_t;

    localparam logic [1:0] FAULT_NONE   = 2'd0;
    localparam logic [1:0] FAULT_SHOOT  = 2'd1;
    localparam logic [1:0] FAULT_ONTIME = 2'd2;

    localparam logic [1:0] LEG_BUCK1 = 2'd0;
    localparam logic [1:0] LEG_BUCK2 = 2'd1;
    localparam logic [1:0] LEG_RES1  = 2'd2;
    localparam logic [1:0] LEG_RES2  = 2'd3;

    localparam int NUM_LEGS = 4;

    // Shoot-through outranks on-time when both hit the same leg together.
    function automatic logic [1:0] leg_fault_code(input logic shoot, input logic ontime);
        if (shoot)       return FAULT_SHOOT;
        else if (ontime) return FAULT_ONTIME;
        else             return FAULT_NONE;
    endfunction

endpackage

// File: rtl/gate_leg_interlock.sv
// One half-bridge leg: dead-time sequencing between the upper and lower
// switch, shoot-through detection and the upper-switch on-time watchdog.
//
//   state        | meaning
//   -------------+--------------------------------------------------------
//   LEG_OFF      | both gates off, waiting for a request
//   LEG_HI_ON    | upper gate on, on-time watchdog running
//   LEG_LO_ON    | lower gate on
//   LEG_DEAD_HL  | upper just turned off, lower held off until dead expires
//   LEG_DEAD_LH  | lower just turned off, upper held off until dead expires
module gate_leg_interlock
    import gate_interlock_pkg::*;
#(
    parameter logic [15:0] DEAD_TIME   = 16'd10,
    parameter logic [15:0] MAX_ON_TIME = 16'd20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_force_off,
    output logic [1:0] o_gate,
    output logic       o_shoot,
    output logic       o_ontime
);

    localparam logic [15:0] ON_LIMIT = MAX_ON_TIME - 16'd1;

    leg_state_t  r_state;
    leg_state_t  w_state_next;
    logic [15:0] r_dead_cnt;
    logic [15:0] r_on_cnt;
    logic [1:0]  r_last_on;   // which switch was on most recently: 10 upper, 01 lower
    logic [1:0]  r_gate;
    logic        w_load_dead;
    logic        w_expired;

    // Dead time is over once the counter would reach zero on this edge, so
    // DEAD_TIME off-cycles separate the switches (never fewer than one).
    assign w_expired = (r_dead_cnt <= 16'd1);
    assign o_shoot   = (i_req == 2'b11);
    assign o_ontime  = (r_state == LEG_HI_ON) && (i_req == 2'b10) && (r_on_cnt == ON_LIMIT);
    assign o_gate    = r_gate;

    // Next-state decode and dead-counter reload requests.
    always_comb begin
        w_state_next = r_state;
        w_load_dead  = 1'b0;
        if (i_force_off || o_shoot) begin
            w_state_next = LEG_OFF;
            w_load_dead  = i_force_off;
        end else begin
            case (r_state)
                LEG_OFF: begin
                    if (i_req == 2'b10 && (w_expired || r_last_on == 2'b10))
                        w_state_next = LEG_HI_ON;
                    else if (i_req == 2'b01 && (w_expired || r_last_on == 2'b01))
                        w_state_next = LEG_LO_ON;
                end
                LEG_HI_ON: begin
                    if (i_req != 2'b10) begin
                        w_load_dead  = 1'b1;
                        w_state_next = (i_req == 2'b01) ? LEG_DEAD_HL : LEG_OFF;
                    end
                end
                LEG_LO_ON: begin
                    if (i_req != 2'b01) begin
                        w_load_dead  = 1'b1;
                        w_state_next = (i_req == 2'b10) ? LEG_DEAD_LH : LEG_OFF;
                    end
                end
                LEG_DEAD_HL: begin
                    if (i_req == 2'b10)
                        w_state_next = LEG_HI_ON;
                    else if (w_expired)
                        w_state_next = (i_req == 2'b01) ? LEG_LO_ON : LEG_OFF;
                end
                LEG_DEAD_LH: begin
                    if (i_req == 2'b01)
                        w_state_next = LEG_LO_ON;
                    else if (w_expired)
                        w_state_next = (i_req == 2'b10) ? LEG_HI_ON : LEG_OFF;
                end
                default: w_state_next = LEG_OFF;
            endcase
        end
    end

    // State, counters and registered gate drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= LEG_OFF;
            r_dead_cnt <= DEAD_TIME;
            r_on_cnt   <= 16'd0;
            r_last_on  <= 2'b00;
            r_gate     <= 2'b00;
        end else begin
            r_state <= w_state_next;
            if (w_load_dead)
                r_dead_cnt <= DEAD_TIME;
            else if (r_dead_cnt != 16'd0)
                r_dead_cnt <= r_dead_cnt - 16'd1;
            if (r_state == LEG_HI_ON && w_state_next == LEG_HI_ON)
                r_on_cnt <= r_on_cnt + 16'd1;
            else
                r_on_cnt <= 16'd0;
            if (i_force_off)
                r_last_on <= 2'b00;
            else if (r_state == LEG_HI_ON)
                r_last_on <= 2'b10;
            else if (r_state == LEG_LO_ON)
                r_last_on <= 2'b01;
            r_gate <= {w_state_next == LEG_HI_ON, w_state_next == LEG_LO_ON};
        end
    end

endmodule

// File: rtl/gate_interlock.sv
// Gate interlock top: four leg interlocks, the deion path, the fault
// priority encoder and the fault latch.
// Optional build macro GATE_GLITCH_FILTER_EN: every request bit must be
// stable for two consecutive samples before the legs see it.
module gate_interlock
    import gate_interlock_pkg::*;
#(
    parameter logic [15:0] DEAD_TIME   = 16'd10,
    parameter logic [15:0] MAX_ON_TIME = 16'd20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mosfet_buck1,
    input  logic [1:0] mosfet_buck2,
    input  logic [1:0] mosfet_res1,
    input  logic [1:0] mosfet_res2,
    input  logic       mosfet_deion,
    input  logic       fault_clear,
    output logic [1:0] gate_buck1,
    output logic [1:0] gate_buck2,
    output logic [1:0] gate_res1,
    output logic [1:0] gate_res2,
    output logic       gate_deion,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [1:0] fault_leg
);

    logic [8:0]          w_raw;
    logic [8:0]          w_req;
    logic [1:0]          w_leg_req  [NUM_LEGS];
    logic [1:0]          w_leg_gate [NUM_LEGS];
    logic [NUM_LEGS-1:0] w_shoot;
    logic [NUM_LEGS-1:0] w_ontime;
    logic                w_viol;
    logic [1:0]          w_code;
    logic [1:0]          w_leg;
    logic                w_fault_set;
    logic                w_clear;
    logic                w_force_off;
    logic                r_fault;
    logic [1:0]          r_fault_code;
    logic [1:0]          r_fault_leg;
    logic                r_deion;

    assign w_raw = {mosfet_buck1, mosfet_buck2, mosfet_res1, mosfet_res2, mosfet_deion};

`ifdef GATE_GLITCH_FILTER_EN
    logic [8:0] r_samp;
    logic [8:0] r_filt;

    // A bit is accepted only when it matches the previous sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_samp <= 9'd0;
            r_filt <= 9'd0;
        end else begin
            r_samp <= w_raw;
            r_filt <= (w_raw & r_samp) | (r_filt & (w_raw ^ r_samp));
        end
    end

    assign w_req = r_filt;
`else
    assign w_req = w_raw;
`endif

    assign w_leg_req[0] = w_req[8:7];
    assign w_leg_req[1] = w_req[6:5];
    assign w_leg_req[2] = w_req[4:3];
    assign w_leg_req[3] = w_req[2:1];

    for (genvar g = 0; g < NUM_LEGS; g++) begin : g_leg
        gate_leg_interlock #(
            .DEAD_TIME  (DEAD_TIME),
            .MAX_ON_TIME(MAX_ON_TIME)
        ) u_leg (
            .clk        (clk),
            .rst        (rst),
            .i_req      (w_leg_req[g]),
            .i_force_off(w_force_off),
            .o_gate     (w_leg_gate[g]),
            .o_shoot    (w_shoot[g]),
            .o_ontime   (w_ontime[g])
        );
    end

    // Lowest-index violating leg wins; scanning downwards lets it overwrite.
    always_comb begin
        w_viol = 1'b0;
        w_code = FAULT_NONE;
        w_leg  = LEG_BUCK1;
        for (int i = NUM_LEGS - 1; i >= 0; i--) begin
            if (w_shoot[i] || w_ontime[i]) begin
                w_viol = 1'b1;
                w_code = leg_fault_code(w_shoot[i], w_ontime[i]);
                w_leg  = 2'(i);
            end
        end
    end

    assign w_fault_set = w_viol && !r_fault;
    assign w_force_off = r_fault || w_fault_set;
    assign w_clear     = r_fault && fault_clear && (w_raw == 9'd0) && (w_req == 9'd0);

    // Fault latch: first violation freezes code and leg until a clean clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault      <= 1'b0;
            r_fault_code <= FAULT_NONE;
            r_fault_leg  <= LEG_BUCK1;
        end else if (w_fault_set) begin
            r_fault      <= 1'b1;
            r_fault_code <= w_code;
            r_fault_leg  <= w_leg;
        end else if (w_clear) begin
            r_fault      <= 1'b0;
            r_fault_code <= FAULT_NONE;
            r_fault_leg  <= LEG_BUCK1;
        end
    end

    // Deion has no sequencing of its own; it is only gated by the fault.
    always_ff @(posedge clk) begin
        if (rst)
            r_deion <= 1'b0;
        else
            r_deion <= w_req[0] && !w_force_off;
    end

    assign gate_buck1 = w_leg_gate[0];
    assign gate_buck2 = w_leg_gate[1];
    assign gate_res1  = w_leg_gate[2];
    assign gate_res2  = w_leg_gate[3];
    assign gate_deion = r_deion;
    assign fault      = r_fault;
    assign fault_code = r_fault_code;
    assign fault_leg  = r_fault_leg;

endmodule

// File: tb/tb_gate_interlock.sv
// Scoreboard bench for gate_interlock: stimulus pushes expected output
// snapshots tagged with a cycle number; the monitor compares on negedge.
module tb_gate_interlock;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mosfet_buck1, mosfet_buck2, mosfet_res1, mosfet_res2;
    logic       mosfet_deion, fault_clear;
    logic [1:0] gate_buck1, gate_buck2, gate_res1, gate_res2;
    logic       gate_deion, fault;
    logic [1:0] fault_code, fault_leg;

    gate_interlock dut (
        .clk         (clk),
        .rst         (rst),
        .mosfet_buck1(mosfet_buck1),
        .mosfet_buck2(mosfet_buck2),
        .mosfet_res1 (mosfet_res1),
        .mosfet_res2 (mosfet_res2),
        .mosfet_deion(mosfet_deion),
        .fault_clear (fault_clear),
        .gate_buck1  (gate_buck1),
        .gate_buck2  (gate_buck2),
        .gate_res1   (gate_res1),
        .gate_res2   (gate_res2),
        .gate_deion  (gate_deion),
        .fault       (fault),
        .fault_code  (fault_code),
        .fault_leg   (fault_leg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [13:0] val;
        logic [13:0] mask;
        string       nm;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [13:0] M_B1  = 14'h3000;
    localparam logic [13:0] M_B2  = 14'h0C00;
    localparam logic [13:0] M_DE  = 14'h0020;
    localparam logic [13:0] M_FLT = 14'h001F;
    localparam logic [13:0] M_ALL = 14'h3FFF;

    wire [13:0] obs = {gate_buck1, gate_buck2, gate_res1, gate_res2, gate_deion,
                       fault, fault_code, fault_leg};

    function automatic logic [13:0] pk(input logic [1:0] b1, input logic [1:0] b2,
                                       input logic [1:0] r1, input logic [1:0] r2,
                                       input logic de, input logic f,
                                       input logic [1:0] code, input logic [1:0] leg);
        return {b1, b2, r1, r2, de, f, code, leg};
    endfunction

    task automatic push(input int dly, input logic [13:0] v, input logic [13:0] m, input string nm);
        exp_t e;
        e.at   = cyc + dly;
        e.val  = v;
        e.mask = m;
        e.nm   = nm;
        sbq.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare every expectation that falls due in this cycle.
    always @(negedge clk) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].at <= cyc) begin
                n_tests++;
                if (sbq[i].at < cyc || ((obs ^ sbq[i].val) & sbq[i].mask) != 14'd0) begin
                    n_fail++;
                    $display("FAIL %s cyc %0d: got %b want %b (mask %b)",
                             sbq[i].nm, cyc, obs, sbq[i].val, sbq[i].mask);
                end
                sbq.delete(i);
            end
        end
    end

    initial begin
        rst = 1'b1; fault_clear = 1'b0; mosfet_deion = 1'b0;
        mosfet_buck1 = 2'b00; mosfet_buck2 = 2'b00; mosfet_res1 = 2'b00; mosfet_res2 = 2'b00;
        tick(1);
        n_tests++;
        if (obs !== 14'd0) begin
            n_fail++;
            $display("FAIL direct_reset: got %b", obs);
        end
        push(1, 14'd0, M_ALL, "reset_state");
        tick(2);
        rst = 1'b0;
        tick(12);

        // nominal 1-cycle latency, buck1 upper and deion
        mosfet_buck1 = 2'b10; mosfet_deion = 1'b1;
        push(1, pk(2'b10, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 2'd0, 2'd0), M_B1 | M_DE, "nominal_hi");
        tick(3);
        n_tests++;
        if (gate_buck1 !== 2'b10 || gate_deion !== 1'b1) begin
            n_fail++;
            $display("FAIL direct_nominal: buck1 %b deion %b", gate_buck1, gate_deion);
        end

        // dead time upper -> lower
        mosfet_buck1 = 2'b01;
        push(1, 14'd0, M_B1, "hi_off");
        for (int k = 2; k <= 10; k++) push(k, 14'd0, M_B1, "no_early_lo");
        push(11, pk(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0), M_B1, "lo_after_dead");
        tick(12);

        // same switch re-asserted goes straight back on
        mosfet_buck1 = 2'b00;
        push(1, 14'd0, M_B1, "lo_drop");
        tick(1);
        mosfet_buck1 = 2'b01;
        push(1, pk(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0), M_B1, "lo_reassert");
        tick(2);

        // single-cycle shoot-through on res2
        mosfet_res2 = 2'b11;
`ifdef GATE_GLITCH_FILTER_EN
        push(1, pk(2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 2'd0, 2'd0), M_ALL, "glitch_no_fault");
`else
        push(1, pk(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 2'd1, 2'd3), M_ALL, "shoot_res2");
`endif
        tick(1);
        mosfet_res2 = 2'b00;
        tick(1);

        // later violation is ignored: code and leg frozen
        mosfet_buck1 = 2'b11;
        push(1, pk(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 2'd1, 2'd3), M_FLT | M_B1, "frozen_code");
        tick(1);

        // clear ignored while a request is active
        mosfet_buck1 = 2'b10; mosfet_deion = 1'b0; fault_clear = 1'b1;
        push(1, pk(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 2'd1, 2'd3), M_FLT | M_B1, "clear_ignored");
        tick(1);
        fault_clear = 1'b0; mosfet_buck1 = 2'b00;
        tick(1);

        // clean clear, then first ON waits full dead time
        fault_clear = 1'b1;
        push(1, 14'd0, M_ALL, "clear_ok");
        tick(1);
        n_tests++;
        if (fault !== 1'b0) begin
            n_fail++;
            $display("FAIL direct_clear: fault %b", fault);
        end
        fault_clear = 1'b0; mosfet_buck1 = 2'b10;
        push(9, 14'd0, M_B1, "post_clear_wait");
        push(10, pk(2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0), M_B1, "post_clear_on");
        tick(12);

        // priority: buck1 and res1 shoot-through together
        mosfet_buck1 = 2'b11; mosfet_res1 = 2'b11;
        push(1, pk(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 2'd1, 2'd0), M_ALL, "prio_leg0");
        tick(1);
        mosfet_buck1 = 2'b00; mosfet_res1 = 2'b00;
        tick(1);
        fault_clear = 1'b1;
        push(1, 14'd0, M_FLT, "prio_clear");
        tick(1);
        fault_clear = 1'b0;
        tick(12);

        // on-time watchdog on buck2 upper
        mosfet_buck2 = 2'b10;
        push(1, pk(2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0), M_B2, "wd_on");
        push(20000, pk(2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0), M_B2 | M_FLT, "wd_last_on");
        push(20001, pk(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 2'd2, 2'd1), M_ALL, "wd_fault");
        tick(20002);
        mosfet_buck2 = 2'b00;
        tick(1);
        n_tests++;
        if (fault !== 1'b1 || fault_code !== 2'd2 || fault_leg !== 2'd1 || gate_buck2 !== 2'b00) begin
            n_fail++;
            $display("FAIL direct_wd: fault %b code %0d leg %0d buck2 %b",
                     fault, fault_code, fault_leg, gate_buck2);
        end
        fault_clear = 1'b1;
        push(1, 14'd0, M_FLT, "wd_clear");
        tick(1);
        fault_clear = 1'b0;
        tick(12);

        // reset in the middle of an upper pulse
        mosfet_buck1 = 2'b10;
        push(1, pk(2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0), M_B1, "pre_rst_on");
        tick(3);
        rst = 1'b1;
        push(1, 14'd0, M_ALL, "rst_mid");
        tick(1);
        n_tests++;
        if (obs !== 14'd0) begin
            n_fail++;
            $display("FAIL direct_rst_mid: got %b", obs);
        end
        rst = 1'b0;
        push(9, 14'd0, M_B1, "rst_wait");
        push(10, pk(2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0), M_B1, "rst_reon");
        tick(12);
        n_tests++;
        if (gate_buck1 !== 2'b10) begin
            n_fail++;
            $display("FAIL direct_rst_reon: buck1 %b", gate_buck1);
        end
        mosfet_buck1 = 2'b00;

        for (int i = 0; i < 50 && sbq.size() != 0; i++) tick(1);
        while (sbq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: never checked, due cyc %0d now %0d", sbq[0].nm, sbq[0].at, cyc);
            void'(sbq.pop_front());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
